// File: rtl/cp0_exception_unit.sv
// ---------------------------------------------------------------------------
// cp0_exception_unit
//
// Purpose:
//   Holds the architectural CP0 registers (Status, Cause, EPC, BadVAddr,
//   Count, Compare), picks the highest-priority exception or interrupt for
//   the instruction at the commit (MEM/WB) boundary, flushes/redirects the
//   pipeline, handles ERET, and serves the MFC0/MTC0 datapath.
//
// Handshake:
//   There is no backpressure. commit_valid qualifies every commit-side input
//   (commit_pc, commit_bd, commit_badvaddr, fault flags, eret) for exactly
//   the cycle it is high; exception_occur/new_pc answer in that same cycle
//   and all register side effects land on the following clock edge.
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   commit_valid         a real instruction is at the commit point
//   commit_pc/bd         PC and delay-slot flag of that instruction
//   commit_badvaddr      faulting data address for load/store errors
//   adel_if .. eret      fault / ERET flags for the committing instruction
//   hw_int               level-sensitive external interrupt lines
//   cp0_we/waddr/wdata   MTC0 write port
//   cp0_raddr/rdata      MFC0 read port (combinational, registered values)
//   exception_occur      flush + redirect this cycle
//   new_pc               redirect target (valid with exception_occur)
//   status_o/cause_o/epc_o  current register values
// ---------------------------------------------------------------------------
module cp0_exception_unit #(
    parameter int          HW_INT_NUM = 6,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
    parameter bit          TIMER_EN   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  commit_valid,
    input  logic [31:0]           commit_pc,
    input  logic                  commit_bd,
    input  logic [31:0]           commit_badvaddr,
    input  logic                  adel_if,
    input  logic                  adel_ld,
    input  logic                  ades,
    input  logic                  ri,
    input  logic                  ov,
    input  logic                  sys,
    input  logic                  bp,
    input  logic                  eret,
    input  logic [HW_INT_NUM-1:0] hw_int,
    input  logic                  cp0_we,
    input  logic [4:0]            cp0_waddr,
    input  logic [31:0]           cp0_wdata,
    input  logic [4:0]            cp0_raddr,
    output logic [31:0]           cp0_rdata,
    output logic                  exception_occur,
    output logic [31:0]           new_pc,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic [31:0]           epc_o
);

    localparam logic [4:0] ADDR_BADVADDR = 5'd8;
    localparam logic [4:0] ADDR_COUNT    = 5'd9;
    localparam logic [4:0] ADDR_COMPARE  = 5'd11;
    localparam logic [4:0] ADDR_STATUS   = 5'd12;
    localparam logic [4:0] ADDR_CAUSE    = 5'd13;
    localparam logic [4:0] ADDR_EPC      = 5'd14;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;

    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

    logic [31:0] r_status;
    logic [31:0] r_cause;
    logic [31:0] r_epc;
    logic [31:0] r_badvaddr;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_prescale;

    logic [5:0]  w_hw_ext;
    logic        w_int_pend;
    logic        w_exc_sel;
    logic [4:0]  w_exc_code;
    logic        w_badv_we;
    logic [31:0] w_badv_val;
    logic        w_eret_take;
    logic        w_mtc0_take;
    logic        w_timer_hit;

    // Missing interrupt lines read as 0 in Cause.IP.
    assign w_hw_ext = 6'(hw_int);

    assign w_int_pend = r_status[0] & ~r_status[1] & (|(r_cause[15:8] & r_status[15:8]));

    // Priority chain; the first matching cause wins.
    always_comb begin
        w_exc_sel  = 1'b0;
        w_exc_code = EXC_INT;
        w_badv_we  = 1'b0;
        w_badv_val = commit_badvaddr;
        if (commit_valid) begin
            if (w_int_pend) begin
                w_exc_sel  = 1'b1;
                w_exc_code = EXC_INT;
            end else if (adel_if) begin
                w_exc_sel  = 1'b1;
                w_exc_code = EXC_ADEL;
                w_badv_we  = 1'b1;
                w_badv_val = commit_pc;
            end else if (ri) begin
                w_exc_sel  = 1'b1;
                w_exc_code = EXC_RI;
            end else if (ov) begin
                w_exc_sel  = 1'b1;
                w_exc_code = EXC_OV;
            end else if (sys) begin
                w_exc_sel  = 1'b1;
                w_exc_code = EXC_SYS;
            end else if (bp) begin
                w_exc_sel  = 1'b1;
                w_exc_code = EXC_BP;
            end else if (adel_ld) begin
                w_exc_sel  = 1'b1;
                w_exc_code = EXC_ADEL;
                w_badv_we  = 1'b1;
            end else if (ades) begin
                w_exc_sel  = 1'b1;
                w_exc_code = EXC_ADES;
                w_badv_we  = 1'b1;
            end
        end
    end

    assign w_eret_take = commit_valid & eret & ~w_exc_sel;
    // A redirect in the same cycle squashes the MTC0.
    assign w_mtc0_take = cp0_we & ~w_exc_sel & ~w_eret_take;
    assign w_timer_hit = TIMER_EN && (r_count == r_compare);

    assign exception_occur = ~rst & (w_exc_sel | w_eret_take);
    assign new_pc          = w_exc_sel ? EXC_VECTOR : r_epc;

    assign status_o = r_status;
    assign cause_o  = r_cause;
    assign epc_o    = r_epc;

    always_comb begin
        cp0_rdata = 32'd0;
        case (cp0_raddr)
            ADDR_BADVADDR: cp0_rdata = r_badvaddr;
            ADDR_COUNT:    cp0_rdata = r_count;
            ADDR_COMPARE:  cp0_rdata = r_compare;
            ADDR_STATUS:   cp0_rdata = r_status;
            ADDR_CAUSE:    cp0_rdata = r_cause;
            ADDR_EPC:      cp0_rdata = r_epc;
            default:       cp0_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_status   <= STATUS_RESET;
            r_cause    <= 32'd0;
            r_epc      <= 32'd0;
            r_badvaddr <= 32'd0;
            r_count    <= 32'd0;
            r_compare  <= 32'd0;
            r_prescale <= 1'b0;
        end else begin
            // Count advances every second cycle; a write restarts the phase.
            if (w_mtc0_take && cp0_waddr == ADDR_COUNT) begin
                r_count    <= cp0_wdata;
                r_prescale <= 1'b0;
            end else begin
                r_prescale <= ~r_prescale;
                if (r_prescale) begin
                    r_count <= r_count + 32'd1;
                end
            end

            if (w_mtc0_take && cp0_waddr == ADDR_COMPARE) begin
                r_compare <= cp0_wdata;
            end

            // Cause.TI is sticky; a Compare write clears it even on a match.
            if (w_mtc0_take && cp0_waddr == ADDR_COMPARE) begin
                r_cause[30] <= 1'b0;
            end else if (w_timer_hit) begin
                r_cause[30] <= 1'b1;
            end

            // Hardware IP bits sample the lines every cycle; IP7 also carries TI.
            r_cause[15]    <= w_hw_ext[5] | r_cause[30];
            r_cause[14:10] <= w_hw_ext[4:0];

            if (w_mtc0_take && cp0_waddr == ADDR_CAUSE) begin
                r_cause[9:8] <= cp0_wdata[9:8];
            end

            if (w_exc_sel) begin
                r_cause[6:2] <= w_exc_code;
                // A nested exception keeps the original return point.
                if (!r_status[1]) begin
                    r_epc       <= commit_bd ? (commit_pc - 32'd4) : commit_pc;
                    r_cause[31] <= commit_bd;
                end
                r_status[1] <= 1'b1;
            end else if (w_eret_take) begin
                r_status[1] <= 1'b0;
            end else if (w_mtc0_take) begin
                if (cp0_waddr == ADDR_STATUS) begin
                    r_status[15:8] <= cp0_wdata[15:8];
                    r_status[1:0]  <= cp0_wdata[1:0];
                end
                if (cp0_waddr == ADDR_EPC) begin
                    r_epc <= cp0_wdata;
                end
            end

            if (w_badv_we) begin
                r_badvaddr <= w_badv_val;
            end
        end
    end

endmodule
